// File: rtl/ahb_stream_loader.sv
// AHB-Lite write-only master: packs a byte stream little-endian into 32-bit words
// and writes each one with a single NONSEQ transfer at incrementing addresses.
module ahb_stream_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned NUM_WORDS = 4096
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        busy,
   output logic        done,
   output logic [15:0] word_count
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_ADDR    = 3'd2;
   localparam logic [2:0] S_DATA    = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [15:0] LAST_COUNT = 16'(NUM_WORDS);

   logic [2:0]  state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [23:0] buf_q, buf_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] haddr_q, haddr_d;
   logic [15:0] count_q, count_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      wdata_d = wdata_q;
      haddr_d = haddr_q;
      count_d = count_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_COLLECT;
               count_d = '0;
               haddr_d = BASE_ADDR;
               idx_d   = '0;
            end
         end
         S_COLLECT: begin
            if (rx_valid) begin
               idx_d = idx_q + 2'd1;
               case (idx_q)
                  2'd0:    buf_d[7:0]   = rx_data;
                  2'd1:    buf_d[15:8]  = rx_data;
                  2'd2:    buf_d[23:16] = rx_data;
                  default: begin
                     wdata_d = {rx_data, buf_q};
                     state_d = S_ADDR;
                  end
               endcase
            end
         end
         S_ADDR: begin
            if (HREADY) state_d = S_DATA;
         end
         S_DATA: begin
            // Address advances with the count so HADDR is ready for the next ADDR phase.
            if (HREADY) begin
               count_d = count_q + 16'd1;
               haddr_d = haddr_q + 32'd4;
               state_d = (count_q + 16'd1 == LAST_COUNT) ? S_DONE : S_COLLECT;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         buf_q   <= '0;
         wdata_q <= '0;
         haddr_q <= BASE_ADDR;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         wdata_q <= wdata_d;
         haddr_q <= haddr_d;
         count_q <= count_d;
      end
   end

   assign rx_ready   = (state_q == S_COLLECT);
   assign HTRANS     = (state_q == S_ADDR) ? 2'b10 : 2'b00;
   assign HWRITE     = (state_q == S_ADDR);
   assign HSIZE      = 3'b010;
   assign HADDR      = haddr_q;
   assign HWDATA     = wdata_q;
   assign busy       = (state_q == S_COLLECT) || (state_q == S_ADDR) || (state_q == S_DATA);
   assign done       = (state_q == S_DONE);
   assign word_count = count_q;

endmodule

// File: tb/tb_ahb_stream_loader.sv
// Directed bench for ahb_stream_loader: four instances with different base/length,
// a transfer logger per instance and a 16KB memory model behind the 4096-word one.
module tb_ahb_stream_loader;

   logic HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   logic        HRESET, HREADY, rx_valid;
   logic [7:0]  rx_data;
   logic        start  [4];
   logic        rr     [4];
   logic [31:0] haddr  [4];
   logic [1:0]  htrans [4];
   logic        hwrite [4];
   logic [2:0]  hsize  [4];
   logic [31:0] hwdata [4];
   logic        busy   [4];
   logic        done   [4];
   logic [15:0] wc     [4];

   int total = 0, passed = 0, tmo = 0;
   int b0, s0, d0, bad;

   logic        dph [4] = '{default: 1'b0};
   logic [31:0] da  [4];
   int          wn  [4] = '{default: 0};
   int          nsc [4] = '{default: 0};
   int          dnc [4] = '{default: 0};
   logic [31:0] wa  [4][16];
   logic [31:0] wd  [4][16];
   logic [31:0] mem [4096];
   logic [31:0] expw [4096];
   logic [7:0]  t1b [4] = '{8'h78, 8'h56, 8'h34, 8'h12};

   ahb_stream_loader #(.BASE_ADDR(32'h0000_0000), .NUM_WORDS(1)) u_one (
      .HCLK(HCLK), .HRESET(HRESET), .start(start[0]), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rr[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]),
      .HWDATA(hwdata[0]), .HREADY(HREADY), .busy(busy[0]), .done(done[0]), .word_count(wc[0]));

   ahb_stream_loader #(.BASE_ADDR(32'h0000_0100), .NUM_WORDS(3)) u_three (
      .HCLK(HCLK), .HRESET(HRESET), .start(start[1]), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rr[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]),
      .HWDATA(hwdata[1]), .HREADY(HREADY), .busy(busy[1]), .done(done[1]), .word_count(wc[1]));

   ahb_stream_loader #(.BASE_ADDR(32'hFFFF_FFF8), .NUM_WORDS(4)) u_wrap (
      .HCLK(HCLK), .HRESET(HRESET), .start(start[2]), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rr[2]), .HADDR(haddr[2]), .HTRANS(htrans[2]), .HWRITE(hwrite[2]), .HSIZE(hsize[2]),
      .HWDATA(hwdata[2]), .HREADY(HREADY), .busy(busy[2]), .done(done[2]), .word_count(wc[2]));

   ahb_stream_loader #(.BASE_ADDR(32'h0000_0000), .NUM_WORDS(4096)) u_big (
      .HCLK(HCLK), .HRESET(HRESET), .start(start[3]), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rr[3]), .HADDR(haddr[3]), .HTRANS(htrans[3]), .HWRITE(hwrite[3]), .HSIZE(hsize[3]),
      .HWDATA(hwdata[3]), .HREADY(HREADY), .busy(busy[3]), .done(done[3]), .word_count(wc[3]));

   // Address phase is latched on HREADY; the write lands when the data phase sees HREADY.
   always @(posedge HCLK) begin
      for (int i = 0; i < 4; i++) begin
         if (HREADY && dph[i]) begin
            wa[i][wn[i] % 16] <= da[i];
            wd[i][wn[i] % 16] <= hwdata[i];
            wn[i] <= wn[i] + 1;
            if (i == 3) mem[da[i][13:2]] <= hwdata[i];
         end
         if (HREADY) begin
            dph[i] <= (htrans[i] == 2'b10) && hwrite[i];
            da[i]  <= haddr[i];
         end
         if (HREADY && htrans[i] == 2'b10) nsc[i] <= nsc[i] + 1;
         if (done[i]) dnc[i] <= dnc[i] + 1;
      end
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic send(input int idx, input logic [7:0] b, input bit gap);
      int n;
      n = 0;
      if (gap) begin
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
         repeat ($urandom_range(2, 0)) tick();
      end
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rr[idx] && n < 64) begin
         tick();
         n++;
      end
      if (n >= 64) tmo++;
      tick();
   endtask

   task automatic wait_done(input int idx, input int limit, input string tag);
      int n;
      n = 0;
      while (!done[idx] && n < limit) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, 32'(done[idx]), 32'd1);
      chk({tag, "_busy_in_done"}, 32'(busy[idx]), 32'd0);
      tick();
      chk({tag, "_done_one_cycle"}, 32'(done[idx]), 32'd0);
   endtask

   initial begin
      HRESET   = 1'b1;
      HREADY   = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      start    = '{default: 1'b0};
      tick();
      tick();
      chk("rst_rx_ready", 32'(rr[0]), 32'd0);
      chk("rst_htrans", 32'(htrans[0]), 32'd0);
      chk("rst_hwrite", 32'(hwrite[0]), 32'd0);
      chk("rst_haddr", haddr[1], 32'h0000_0100);
      chk("rst_hwdata", hwdata[0], 32'd0);
      chk("rst_busy", 32'(busy[0]), 32'd0);
      chk("rst_done", 32'(done[0]), 32'd0);
      chk("rst_word_count", 32'(wc[0]), 32'd0);
      HRESET = 1'b0;
      tick();

      // Single-word load, cycle exact with rx_valid held high.
      start[0] = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h78;
      tick();
      start[0] = 1'b0;
      chk("one_busy", 32'(busy[0]), 32'd1);
      chk("one_rx_ready", 32'(rr[0]), 32'd1);
      for (int k = 0; k < 4; k++) begin
         rx_data = t1b[k];
         tick();
      end
      chk("one_addr_htrans", 32'(htrans[0]), 32'h2);
      chk("one_addr_hwrite", 32'(hwrite[0]), 32'd1);
      chk("one_addr_haddr", haddr[0], 32'h0000_0000);
      chk("one_addr_hsize", 32'(hsize[0]), 32'h2);
      chk("one_addr_rx_ready", 32'(rr[0]), 32'd0);
      tick();
      chk("one_data_htrans", 32'(htrans[0]), 32'd0);
      chk("one_data_hwrite", 32'(hwrite[0]), 32'd0);
      chk("one_data_hwdata", hwdata[0], 32'h1234_5678);
      chk("one_data_rx_ready", 32'(rr[0]), 32'd0);
      chk("one_data_done", 32'(done[0]), 32'd0);
      tick();
      chk("one_done", 32'(done[0]), 32'd1);
      chk("one_word_count", 32'(wc[0]), 32'd1);
      chk("one_busy_done", 32'(busy[0]), 32'd0);
      tick();
      chk("one_done_low", 32'(done[0]), 32'd0);
      chk("one_nonseq_count", 32'(nsc[0]), 32'd1);
      chk("one_done_count", 32'(dnc[0]), 32'd1);
      rx_valid = 1'b0;

      // Three words at 0x100 with a continuous stream.
      b0 = wn[1]; s0 = nsc[1]; d0 = dnc[1];
      start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      for (int k = 0; k < 12; k++) send(1, 8'(k), 1'b0);
      rx_valid = 1'b0;
      wait_done(1, 20, "t2");
      chk("t2_writes", 32'(wn[1] - b0), 32'd3);
      chk("t2_nonseq", 32'(nsc[1] - s0), 32'd3);
      chk("t2_done_count", 32'(dnc[1] - d0), 32'd1);
      chk("t2_word_count", 32'(wc[1]), 32'd3);
      for (int k = 0; k < 3; k++) begin
         chk("t2_addr", wa[1][(b0 + k) % 16], 32'h100 + 32'(4 * k));
         chk("t2_data", wd[1][(b0 + k) % 16], 32'h0302_0100 + 32'(k) * 32'h0404_0404);
      end

      // Wait states in both phases, then a gappy stream with a stray start.
      b0 = wn[1]; s0 = nsc[1]; d0 = dnc[1];
      start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      HREADY = 1'b0;
      for (int k = 0; k < 4; k++) send(1, 8'(8'hA0 + k), 1'b0);
      rx_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("st_addr_htrans", 32'(htrans[1]), 32'h2);
         chk("st_addr_haddr", haddr[1], 32'h0000_0100);
         chk("st_addr_hwrite", 32'(hwrite[1]), 32'd1);
         if (c == 2) HREADY = 1'b1;
         tick();
      end
      chk("st_data_htrans", 32'(htrans[1]), 32'd0);
      chk("st_data_hwdata", hwdata[1], 32'hA3A2_A1A0);
      HREADY = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("st_data_hold", hwdata[1], 32'hA3A2_A1A0);
         chk("st_count_hold", 32'(wc[1]), 32'd0);
      end
      HREADY = 1'b1;
      tick();
      chk("st_count_inc", 32'(wc[1]), 32'd1);
      chk("st_back_collect", 32'(rr[1]), 32'd1);
      for (int k = 0; k < 8; k++) begin
         send(1, 8'(8'hB0 + k), 1'b1);
         if (k == 1) begin
            rx_valid = 1'b0;
            start[1] = 1'b1;
            tick();
            start[1] = 1'b0;
            chk("st_start_ignored", 32'(wc[1]), 32'd1);
         end
      end
      rx_valid = 1'b0;
      wait_done(1, 40, "t3");
      chk("t3_writes", 32'(wn[1] - b0), 32'd3);
      chk("t3_nonseq", 32'(nsc[1] - s0), 32'd3);
      chk("t3_done_count", 32'(dnc[1] - d0), 32'd1);
      chk("t3_addr0", wa[1][b0 % 16], 32'h0000_0100);
      chk("t3_data0", wd[1][b0 % 16], 32'hA3A2_A1A0);
      chk("t3_addr1", wa[1][(b0 + 1) % 16], 32'h0000_0104);
      chk("t3_data1", wd[1][(b0 + 1) % 16], 32'hB3B2_B1B0);
      chk("t3_addr2", wa[1][(b0 + 2) % 16], 32'h0000_0108);
      chk("t3_data2", wd[1][(b0 + 2) % 16], 32'hB7B6_B5B4);

      // Reset two bytes into word 1, with start coincident; then a clean load that wraps.
      start[2] = 1'b1;
      tick();
      start[2] = 1'b0;
      send(2, 8'h44, 1'b0); send(2, 8'h33, 1'b0); send(2, 8'h22, 1'b0); send(2, 8'h11, 1'b0);
      send(2, 8'h55, 1'b0); send(2, 8'h66, 1'b0);
      rx_valid = 1'b0;
      HRESET   = 1'b1;
      start[2] = 1'b1;
      tick();
      HRESET   = 1'b0;
      start[2] = 1'b0;
      chk("mr_haddr", haddr[2], 32'hFFFF_FFF8);
      chk("mr_htrans", 32'(htrans[2]), 32'd0);
      chk("mr_hwrite", 32'(hwrite[2]), 32'd0);
      chk("mr_hwdata", hwdata[2], 32'd0);
      chk("mr_busy", 32'(busy[2]), 32'd0);
      chk("mr_rx_ready", 32'(rr[2]), 32'd0);
      chk("mr_word_count", 32'(wc[2]), 32'd0);
      s0 = nsc[2];
      repeat (6) tick();
      chk("mr_no_nonseq", 32'(nsc[2] - s0), 32'd0);
      chk("mr_still_idle", 32'(busy[2]), 32'd0);
      b0 = wn[2]; d0 = dnc[2];
      start[2] = 1'b1;
      tick();
      start[2] = 1'b0;
      for (int k = 0; k < 16; k++) send(2, 8'(8'h80 + k), 1'b0);
      rx_valid = 1'b0;
      wait_done(2, 20, "t4");
      chk("t4_writes", 32'(wn[2] - b0), 32'd4);
      chk("t4_word_count", 32'(wc[2]), 32'd4);
      chk("t4_done_count", 32'(dnc[2] - d0), 32'd1);
      for (int k = 0; k < 4; k++) begin
         chk("t4_addr", wa[2][(b0 + k) % 16], 32'hFFFF_FFF8 + 32'(4 * k));
         chk("t4_data", wd[2][(b0 + k) % 16], 32'h8382_8180 + 32'(k) * 32'h0404_0404);
      end

      // Full 16KB image into the memory model.
      s0 = nsc[3]; d0 = dnc[3];
      for (int w = 0; w < 4096; w++) expw[w] = $urandom;
      start[3] = 1'b1;
      tick();
      start[3] = 1'b0;
      for (int w = 0; w < 4096; w++)
         for (int k = 0; k < 4; k++) send(3, expw[w][8 * k +: 8], 1'b0);
      rx_valid = 1'b0;
      wait_done(3, 20, "big");
      bad = 0;
      for (int w = 0; w < 4096; w++)
         if (mem[w] !== expw[w]) bad++;
      chk("big_mem_bad_words", 32'(bad), 32'd0);
      chk("big_word_count", 32'(wc[3]), 32'd4096);
      chk("big_nonseq", 32'(nsc[3] - s0), 32'd4096);
      chk("big_done_count", 32'(dnc[3] - d0), 32'd1);
      chk("byte_timeouts", 32'(tmo), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ahb_stream_loader.md
Name: ahb_stream_loader

Overview:
- AHB-Lite write-only master that sits directly upstream of the on-chip 16KB AHB memory slave.
- Accepts a byte stream (from the UART receiver) through a valid/ready handshake.
- Assembles the bytes little-endian into 32-bit words.
- Writes each word with a single NONSEQ word transfer at incrementing addresses from BASE_ADDR. It loads the program image before the CPU is released.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned.
- NUM_WORDS, 4096, number of words per load (16KB image); range 1..65535.

Ports:
- HCLK  input  1  system clock; all logic on its rising edge.
- HRESET  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; ignored while busy=1.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts a byte this cycle (byte taken when rx_valid & rx_ready).
- HADDR  output  32  AHB address.
- HTRANS  output  2  AHB transfer type: 2'b00 IDLE or 2'b10 NONSEQ only.
- HWRITE  output  1  AHB write.
- HSIZE  output  3  AHB size, constant 3'b010.
- HWDATA  output  32  AHB write data.
- HREADY  input  1  bus HREADY (from the slave / HREADYOUT mux).
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse when the last word's data phase completes.
- word_count  output  16  words completed in the current or last load.

Behaviour:
- Reset values (HRESET=1 at a rising edge, including mid-load): state IDLE, rx_ready=0, HTRANS=2'b00, HWRITE=0, HADDR=BASE_ADDR, HWDATA=0, busy=0, done=0, word_count=0, byte index=0. Any partially assembled word is discarded. No AHB transfer is issued in the cycle after reset.
- IDLE:
  - rx_ready=0, HTRANS=IDLE, busy=0.
  - start=1 -> COLLECT; word_count<=0, HADDR<=BASE_ADDR, byte index<=0.
- COLLECT:
  - rx_ready=1, busy=1.
  - Each accepted byte k (k=0..3) goes to word[8k+7:8k]; the first byte lands in [7:0].
  - On the 4th accepted byte -> ADDR; the assembled word is latched into the write-data register.
- ADDR:
  - rx_ready=0, HTRANS=NONSEQ, HWRITE=1, HSIZE=3'b010, HADDR=BASE_ADDR+4*word_count.
  - HREADY=1 -> DATA. HREADY=0 -> stay, with address/control held stable.
- DATA:
  - HTRANS=IDLE, HWRITE=0, HWDATA=assembled word, held stable while HREADY=0.
  - HREADY=1: word_count increments. If the new count equals NUM_WORDS -> DONE, else -> COLLECT.
- DONE: done=1 for exactly one cycle, busy=0, then -> IDLE. word_count keeps its final value until the next start.
- Timing and bus rules:
  - Minimum cost per word with a zero-wait slave is 6 cycles (4 COLLECT + ADDR + DATA).
  - Transfers are never pipelined back-to-back; HTRANS is never BUSY or SEQ.
  - Only whole words are written; a trailing partial word at stream end never reaches the bus.
- Boundaries:
  - start while busy: ignored.
  - rx_valid while not COLLECT: byte not consumed, because rx_ready=0.
  - HADDR increments by 4 with 32-bit wrap.
  - start coincident with HRESET: reset wins.
  - NUM_WORDS=1: a single write, then done.

Test Plan:
- Reset, start, stream bytes 0x78,0x56,0x34,0x12 with rx_valid always 1, HREADY=1, NUM_WORDS=1:
  - NONSEQ write at HADDR=0x0000_0000, next cycle HWDATA=0x1234_5678.
  - done pulses one cycle after that data phase; word_count=1; rx_ready=0 during ADDR/DATA.
- NUM_WORDS=3, BASE_ADDR=0x0000_0100, bytes 0x00..0x0B:
  - Writes at 0x100/0x104/0x108 with data 0x03020100, 0x07060504, 0x0B0A0908.
  - Exactly 3 NONSEQ cycles; single done.
- Hold HREADY=0 for 3 cycles during ADDR, then 2 cycles during DATA:
  - HADDR/HTRANS/HWRITE stable through the ADDR stall, HWDATA stable through the DATA stall.
  - word_count increments only when the data phase sees HREADY=1.
- Toggle rx_valid randomly (1 of 3 cycles):
  - Only bytes with rx_valid&rx_ready are assembled; written words equal the byte sequence.
  - start pulsed mid-load has no effect.
- Assert HRESET after 2 of 4 bytes of word 1 (NUM_WORDS=4):
  - All outputs return to reset values next cycle; no NONSEQ follows.
  - A new start then writes from BASE_ADDR with the first 4 new bytes.
- NUM_WORDS=4096, connected to the 16KB memory slave, random bytes:
  - Read back all 4096 words through the slave and compare against the stream.
  - done asserted once; word_count=4096.
